// File: rtl/vending_machine_change.sv
// rtl/vending_machine_change.sv - coin-operated vending FSM with dime/nickel change return
// Moore outputs decode state and credit; only coin_reject is a separately registered pulse.
module vending_machine_change #(
  parameter int PRICE = 15,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          nickel,
  input  logic          dime,
  input  logic          quarter,
  input  logic          cancel,
  output logic          dispense,
  output logic          chg_dime,
  output logic          chg_nickel,
  output logic          coin_reject,
  output logic          busy,
  output logic [CW-1:0] credit
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] PRICE_C  = CW'(PRICE);
  localparam logic [CW-1:0] NICKEL_C = CW'(5);
  localparam logic [CW-1:0] DIME_C   = CW'(10);
  localparam logic [CW-1:0] QUART_C  = CW'(25);

  state_t        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          coin_reject_q, coin_reject_d;
  logic [CW-1:0] coin_val;
  logic          any_coin;

  assign any_coin = nickel | dime | quarter;

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_reject_d = 1'b0;
    coin_val      = '0;
    case (state_q)
      COLLECT: begin
        if (cancel && (credit_q != '0)) begin
          // Refund wins over any coin offered in the same cycle.
          state_d       = CHANGE;
          coin_reject_d = any_coin;
        end else begin
          if (quarter) begin
            coin_val      = QUART_C;
            coin_reject_d = dime | nickel;
          end else if (dime) begin
            coin_val      = DIME_C;
            coin_reject_d = nickel;
          end else if (nickel) begin
            coin_val = NICKEL_C;
          end
          credit_d = credit_q + coin_val;
          if (credit_d >= PRICE_C) state_d = VEND;
        end
      end
      VEND: begin
        coin_reject_d = any_coin;
        credit_d      = credit_q - PRICE_C;
        state_d       = (credit_d != '0) ? CHANGE : COLLECT;
      end
      CHANGE: begin
        coin_reject_d = any_coin;
        credit_d      = credit_q - ((credit_q >= DIME_C) ? DIME_C : NICKEL_C);
        if (credit_d == '0) state_d = COLLECT;
      end
      default: begin
        state_d  = COLLECT;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= COLLECT;
      credit_q      <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  // CHANGE is only ever entered with non-zero credit, so exactly one change line is active there.
  assign dispense    = (state_q == VEND);
  assign chg_dime    = (state_q == CHANGE) && (credit_q >= DIME_C);
  assign chg_nickel  = (state_q == CHANGE) && (credit_q < DIME_C);
  assign busy        = (state_q != COLLECT);
  assign coin_reject = coin_reject_q;
  assign credit      = credit_q;

endmodule
